// File: rtl/oam_dma_controller_if.sv
// CPU-side and memory-map-side bus bundle for the NES sprite DMA controller.
// The slave modport is the controller; the master modport is the CPU/memory-map environment.
interface oam_dma_controller_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_r_nw;
  logic [DATA_W-1:0] bus_din;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_halt;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_dout;
  logic              bus_r_nw;
  logic              dma_busy;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    output cpu_din, cpu_halt, bus_addr, bus_dout, bus_r_nw, dma_busy
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    input  cpu_din, cpu_halt, bus_addr, bus_dout, bus_r_nw, dma_busy
  );
endinterface

// File: rtl/oam_dma_controller.sv
// NES $4014 sprite DMA: halts the CPU and copies page $PP00-$PPFF to OAM data port $2004.
// Optional OAM_DMA_ODD_ALIGN_EN adds the parity ALIGN cycle (513/514-cycle transfers).
module oam_dma_controller #(
  parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  clk_ph1,
  input  logic                  rst,
  oam_dma_controller_if.slave   dma
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  data_q;
  logic        run_q;
`ifdef OAM_DMA_ODD_ALIGN_EN
  logic        cyc_odd_q;
`endif

  logic trigger;
  assign trigger = (dma.cpu_addr == DMA_TRIG_ADDR) && !dma.cpu_r_nw;

  // Sequencer; run_q mirrors (state != IDLE) as a flop so halt/busy are glitch-free.
  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state_q   <= S_IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      data_q    <= 8'h00;
      run_q     <= 1'b0;
`ifdef OAM_DMA_ODD_ALIGN_EN
      cyc_odd_q <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_ODD_ALIGN_EN
      cyc_odd_q <= ~cyc_odd_q;
`endif
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_q  <= dma.cpu_dout;
            idx_q   <= 8'h00;
            state_q <= S_HALT;
            run_q   <= 1'b1;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          state_q <= cyc_odd_q ? S_READ : S_ALIGN;
`else
          state_q <= S_READ;
`endif
        end
        S_ALIGN: state_q <= S_READ;
        S_READ: begin
          data_q  <= dma.bus_din;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          idx_q <= idx_q + 8'd1;
          if (idx_q == 8'hFF) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
          end else begin
            state_q <= S_READ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus arbitration: CPU pass-through in IDLE, dummy reads while halting, DMA cycles otherwise.
  always_comb begin
    dma.bus_addr = dma.cpu_addr;
    dma.bus_dout = dma.cpu_dout;
    dma.bus_r_nw = dma.cpu_r_nw;
    case (state_q)
      S_HALT, S_ALIGN: dma.bus_r_nw = 1'b1;
      S_READ: begin
        dma.bus_addr = {page_q, idx_q};
        dma.bus_dout = data_q;
        dma.bus_r_nw = 1'b1;
      end
      S_WRITE: begin
        dma.bus_addr = OAM_DATA_ADDR;
        dma.bus_dout = data_q;
        dma.bus_r_nw = 1'b0;
      end
      default: ;
    endcase
  end

  assign dma.cpu_din  = dma.bus_din;
  assign dma.cpu_halt = run_q;
  assign dma.dma_busy = run_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: table vectors in IDLE plus full transfers
// checked cycle by cycle against an expected bus trace built from the transfer rules.
module tb_oam_dma_controller;

  logic clk;
  logic rst;
  oam_dma_controller_if ifc();

  oam_dma_controller dut (
    .clk_ph1 (clk),
    .rst     (rst),
    .dma     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] cyc_cnt;
  logic [7:0]  model_data;

  // Memory map contents: page $02 holds nn^$5A; other pages are scrambled by page.
  function automatic logic [7:0] memval(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] - 8'h02;
    return a[7:0] ^ 8'h5A ^ hi;
  endfunction

  assign ifc.bus_din = memval(ifc.bus_addr);

  // Clock parity since the last reset edge.
  always @(posedge clk) cyc_cnt <= rst ? 32'd0 : cyc_cnt + 32'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string tg, input logic [15:0] ea, input logic [7:0] ed,
                         input logic er, input logic eh);
    chk({tg, ".bus_addr"}, 32'(ifc.bus_addr), 32'(ea));
    chk({tg, ".bus_dout"}, 32'(ifc.bus_dout), 32'(ed));
    chk({tg, ".bus_r_nw"}, 32'(ifc.bus_r_nw), 32'(er));
    chk({tg, ".cpu_halt"}, 32'(ifc.cpu_halt), 32'(eh));
    chk({tg, ".dma_busy"}, 32'(ifc.dma_busy), 32'(eh));
    chk({tg, ".cpu_din"},  32'(ifc.cpu_din),  32'(memval(ea)));
  endtask

  task automatic drive_safe();
    ifc.cpu_addr = 16'($urandom);
    ifc.cpu_dout = 8'($urandom);
    ifc.cpu_r_nw = 1'($urandom);
    if (ifc.cpu_addr == 16'h4014) ifc.cpu_r_nw = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      drive_safe();
      @(negedge clk);
      chk_bus("idle", ifc.cpu_addr, ifc.cpu_dout, ifc.cpu_r_nw, 1'b0);
    end
  endtask

  // Ensure the next (trigger) cycle has parity p.
  task automatic park(input logic p);
    if (cyc_cnt[0] == p) idle_cycles(1);
  endtask

  // One DMA: trigger, then every halted cycle checked against the expected trace.
  task automatic do_xfer(input logic [7:0] pg, input int abort_k, input bit noisy);
    int align, total, nh, k;
    logic [7:0] i;
    logic [15:0] ea;
    logic [7:0] ed;
    logic er;
    @(posedge clk); #1;
    ifc.cpu_addr = 16'h4014; ifc.cpu_dout = pg; ifc.cpu_r_nw = 1'b0;
    @(negedge clk);
    chk_bus("trig", 16'h4014, pg, 1'b0, 1'b0);
    align = 0;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (cyc_cnt[0] == 1'b1) align = 1;
`endif
    total = 1 + align + 512;
    nh = 0;
    for (int n = 0; n < total; n++) begin
      @(posedge clk); #1;
      if (noisy) begin
        ifc.cpu_addr = 16'($urandom);
        ifc.cpu_dout = 8'($urandom);
        ifc.cpu_r_nw = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          ifc.cpu_addr = 16'h4014; ifc.cpu_dout = 8'h07; ifc.cpu_r_nw = 1'b0;
        end
      end else begin
        ifc.cpu_addr = 16'h0000; ifc.cpu_dout = 8'h00; ifc.cpu_r_nw = 1'b1;
      end
      k = n - 1 - align;
      if (abort_k >= 0 && k == abort_k) rst = 1'b1;
      @(negedge clk);
      if (k < 0) begin
        ea = ifc.cpu_addr; ed = ifc.cpu_dout; er = 1'b1;
        chk_bus("dummy", ea, ed, er, 1'b1);
      end else begin
        i = 8'(k >> 1);
        if (k % 2 == 0) begin
          chk_bus("read", {pg, i}, model_data, 1'b1, 1'b1);
          model_data = memval({pg, i});
        end else begin
          chk_bus("write", 16'h2004, model_data, 1'b0, 1'b1);
        end
      end
      if (ifc.cpu_halt === 1'b1) nh++;
      if (abort_k >= 0 && k == abort_k) begin
        @(posedge clk); #1;
        rst = 1'b0;
        drive_safe();
        model_data = 8'h00;
        @(negedge clk);
        chk_bus("abort", ifc.cpu_addr, ifc.cpu_dout, ifc.cpu_r_nw, 1'b0);
        return;
      end
    end
    chk("halt_cycles", 32'(nh), 32'(total));
    @(posedge clk); #1;
    ifc.cpu_addr = 16'h1234; ifc.cpu_dout = 8'hC3; ifc.cpu_r_nw = 1'b1;
    @(negedge clk);
    chk_bus("post", 16'h1234, 8'hC3, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_rnw;
    logic        e_halt;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{16'h4014, 8'h11, 1'b1, 16'h4014, 8'h11, 1'b1, 1'b0};
    vt[1] = '{16'h4015, 8'h55, 1'b0, 16'h4015, 8'h55, 1'b0, 1'b0};
    vt[2] = '{16'h2004, 8'hA5, 1'b0, 16'h2004, 8'hA5, 1'b0, 1'b0};
    vt[3] = '{16'h0000, 8'h3C, 1'b1, 16'h0000, 8'h3C, 1'b1, 1'b0};
    vt[4] = '{16'h4013, 8'h02, 1'b0, 16'h4013, 8'h02, 1'b0, 1'b0};
    vt[5] = '{16'h4014, 8'h09, 1'b1, 16'h4014, 8'h09, 1'b1, 1'b0};

    rst = 1'b1;
    ifc.cpu_addr = 16'h0000; ifc.cpu_dout = 8'h00; ifc.cpu_r_nw = 1'b1;
    model_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ifc.cpu_addr = 16'h0100; ifc.cpu_dout = 8'h77; ifc.cpu_r_nw = 1'b0;
    @(negedge clk);
    chk_bus("reset", 16'h0100, 8'h77, 1'b0, 1'b0);

    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      ifc.cpu_addr = vt[v].addr; ifc.cpu_dout = vt[v].dout; ifc.cpu_r_nw = vt[v].rnw;
      @(negedge clk);
      chk_bus($sformatf("vec%0d", v), vt[v].e_addr, vt[v].e_dout, vt[v].e_rnw, vt[v].e_halt);
    end
    idle_cycles(1);

    // Page $02, HALT on odd cycle, quiet CPU.
    park(1'b0);
    do_xfer(8'h02, -1, 1'b0);
    // Page $02, HALT on even cycle, noisy CPU incl. $4014 writes of $07.
    park(1'b1);
    do_xfer(8'h02, -1, 1'b1);
    // Top page and the PPU register page.
    idle_cycles(2);
    do_xfer(8'hFF, -1, 1'b1);
    do_xfer(8'h20, -1, 1'b0);
    // Reset on transfer cycle 100 (idx 50), then a clean restart.
    park(1'b0);
    do_xfer(8'h02, 100, 1'b1);
    idle_cycles(1);
    do_xfer(8'h03, -1, 1'b0);
    // Random pages, random alignment.
    for (int r = 0; r < 3; r++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      do_xfer(8'($urandom), -1, 1'b1);
    end
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the NES sprite DMA ($4014) and arbitrates the shared external CPU bus between the CPU and the DMA engine.
- A CPU write to $4014 captures a page number P and freezes the CPU through a halt line.
- The block then copies 256 bytes from $PP00-$PPFF to the PPU OAM data port $2004 with alternating read/write cycles, and returns the bus to the CPU.
- It sits between the CPU's address/data/R_nW outputs and the system memory map.

Parameters:
- DMA_TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written during each transfer write cycle.

Ports:
- clk_ph1  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- cpu_addr  input  16  CPU address bus.
- cpu_dout  input  8  CPU write data.
- cpu_r_nw  input  1  CPU read/not-write.
- bus_din  input  8  read data returned from the memory map.
- cpu_din  output  8  read data to the CPU; always equals bus_din.
- cpu_halt  output  1  1 = CPU must freeze all state this cycle.
- bus_addr  output  16  arbitrated address to the memory map.
- bus_dout  output  8  arbitrated write data.
- bus_r_nw  output  1  arbitrated read/not-write.
- dma_busy  output  1  1 while state != IDLE.

Behaviour:
- Decided interface: one clock (clk_ph1); rst is synchronous and active-high.
- Registers:
  - state: IDLE, HALT, ALIGN, READ, WRITE.
  - page[7:0].
  - idx[7:0].
  - data[7:0].
  - cyc_odd: toggles every clock, reset 0.
- Reset (rst=1 at an edge):
  - state=IDLE, page=0, idx=0, data=0, cyc_odd=0.
  - Outputs after reset: cpu_halt=0, dma_busy=0, bus passes CPU signals.
- Trigger: in IDLE, an edge seeing cpu_addr==DMA_TRIG_ADDR and cpu_r_nw=0 does three things:
  - latches page<=cpu_dout;
  - sets idx<=0;
  - moves to HALT.
  - The triggering write itself passes through to the bus unchanged.
- IDLE:
  - bus_addr/bus_dout/bus_r_nw = cpu_addr/cpu_dout/cpu_r_nw (combinational pass-through).
  - cpu_halt=0.
- HALT (1 cycle):
  - cpu_halt=1.
  - Bus drives a dummy read: bus_addr=cpu_addr, bus_r_nw=1, bus_dout=cpu_dout.
  - Next state: READ if cyc_odd==1 in this cycle, else ALIGN.
- ALIGN (1 cycle):
  - cpu_halt=1; dummy read as in HALT.
  - Next state: READ.
  - Guarantees every READ cycle has cyc_odd==0.
- READ:
  - cpu_halt=1, bus_addr={page,idx}, bus_r_nw=1, bus_dout=data.
  - At the edge: data<=bus_din, next state WRITE.
- WRITE:
  - cpu_halt=1, bus_addr=OAM_DATA_ADDR, bus_dout=data, bus_r_nw=0.
  - At the edge: if idx==8'hFF go to IDLE and leave idx wrapping to 0; else idx<=idx+1 and go to READ.
- Latency: the trigger edge is followed by 1 HALT cycle, 0 or 1 ALIGN cycles, then 512 transfer cycles. Total halted cycles are 513 or 514.
- cpu_halt falls in the first IDLE cycle; the CPU resumes on that cycle.
- Outputs:
  - cpu_halt and dma_busy are decoded from registered state, so they are glitch-free.
  - Bus outputs are a combinational mux on state.
- Boundaries:
  - idx wraps 8'hFF->8'h00 only on the final WRITE. No partial transfers.
  - Page 8'hFF reads $FF00-$FFFF; no address overflow.
  - Page 8'h20 reads $2000-$20FF; the block performs those reads normally, with no special-casing.
  - Writes to DMA_TRIG_ADDR while state != IDLE are ignored: the CPU is halted, and its bus signals are neither decoded nor forwarded.
  - A CPU read of DMA_TRIG_ADDR never triggers.
  - rst asserted in any state: next cycle is IDLE, cpu_halt=0, and the bus returns to pass-through. The interrupted transfer is abandoned, not resumed.

Optional Feature:
- Macro: OAM_DMA_ODD_ALIGN_EN.
- Defined: ALIGN behaves as above, giving parity-dependent 513/514-cycle transfers that match NES hardware.
- Not defined:
  - ALIGN is never entered; HALT always proceeds to READ.
  - Every transfer takes exactly 513 halted cycles.
  - cyc_odd may be removed.

Test Plan:
- Reset, then CPU writes 8'h02 to $4014 with cyc_odd==1 in HALT: bus shows reads $0200..$02FF alternating with writes to $2004 carrying the read bytes (memory preloaded mem[$02nn]=nn^8'h5A). cpu_halt is high exactly 513 cycles.
- Same trigger with HALT landing on cyc_odd==0 and OAM_DMA_ODD_ALIGN_EN defined: cpu_halt high 514 cycles and the first READ has cyc_odd==0. Without the macro: 513 cycles.
- Page 8'hFF: last READ addr=$FFFF, final WRITE to $2004, then IDLE, idx==0, and bus passes cpu_addr the next cycle.
- During transfer, CPU model drives $4014 write with 8'h07 and cpu_r_nw=0: no restart, page stays 8'h02, total count unchanged. CPU read of $4014 while IDLE: no trigger.
- rst=1 on transfer cycle 100 (idx=50): next cycle state=IDLE, cpu_halt=0, dma_busy=0, bus_addr==cpu_addr. A new $4014 write then starts cleanly at idx=0.
- CPU write to $4015 or $2004 while IDLE: passes to the bus unchanged, cpu_halt stays 0.
